// File: rtl/game_sound_gen_if.sv
// rtl/game_sound_gen_if.sv - game-event to sound generator interface
interface game_sound_gen_if;
    logic       winrnd;
    logic       right;
    logic       tie;
    logic [6:0] score;
    logic       sound_en;
    logic       spk;
    logic       busy;

    modport master (
        output winrnd, right, tie, score, sound_en,
        input  spk, busy
    );

    modport slave (
        input  winrnd, right, tie, score, sound_en,
        output spk, busy
    );
endinterface

// File: rtl/game_sound_gen.sv
// rtl/game_sound_gen.sv - square-wave tone sequencer for round, tie and match-end events
module game_sound_gen #(
    parameter int HALF_R = 2,
    parameter int HALF_L = 3,
    parameter int HALF_T = 4,
    parameter int DUR    = 16,
    parameter int GAP    = 4,
    parameter int CW     = 8
) (
    input  logic             clk,
    input  logic             rst,
    game_sound_gen_if.slave  ev
);
    typedef enum logic [1:0] {ST_IDLE, ST_NOTE, ST_GAP} state_t;

    localparam logic [CW-1:0] HR     = CW'(HALF_R);
    localparam logic [CW-1:0] HL     = CW'(HALF_L);
    localparam logic [CW-1:0] HT     = CW'(HALF_T);
    localparam logic [CW-1:0] DUR_M1 = CW'(DUR - 1);
    localparam logic [CW-1:0] GAP_M1 = CW'(GAP - 1);
    localparam logic [6:0]    END_L  = 7'b1000000;
    localparam logic [6:0]    END_R  = 7'b0000001;
    localparam logic [6:0]    MID    = 7'b0001000;

    state_t        state, state_n;
    logic [1:0]    idx, idx_n;
    logic [1:0]    last_idx, last_idx_n;
    logic [CW-1:0] base_q, base_n;
    logic [CW-1:0] alt_q, alt_n;
    logic [CW-1:0] hp_cnt, hp_n;
    logic [CW-1:0] dur_cnt, dur_n;
    logic          spk_raw, spk_raw_n;
    logic          spk_q;
    logic [6:0]    score_q;

    logic          victory;
    logic          start;
    logic [CW-1:0] st_base, st_alt;
    logic [1:0]    st_last;
    logic [CW-1:0] cur_half;

    // Odd notes (only note 1) use the alternate pitch; notes 0 and 2 share the base pitch.
    assign cur_half = idx[0] ? alt_q : base_q;
    assign victory  = (ev.score != score_q) && ((ev.score == END_L) || (ev.score == END_R));

    always_comb begin
        start   = 1'b0;
        st_base = HR;
        st_alt  = HT;
        st_last = 2'd0;
        if (victory) begin
            start   = 1'b1;
            st_base = (ev.score == END_L) ? HL : HR;
            st_alt  = HT;
            st_last = 2'd2;
        end else if (state == ST_IDLE && ev.tie) begin
            start   = 1'b1;
            st_base = HT;
            st_alt  = HT;
            st_last = 2'd1;
        end else if (state == ST_IDLE && ev.winrnd) begin
            start   = 1'b1;
            st_base = ev.right ? HR : HL;
            st_last = 2'd0;
        end
    end

    always_comb begin
        state_n    = state;
        idx_n      = idx;
        last_idx_n = last_idx;
        base_n     = base_q;
        alt_n      = alt_q;
        hp_n       = hp_cnt;
        dur_n      = dur_cnt;
        spk_raw_n  = spk_raw;
        if (start) begin
            // Victory may land here mid-sequence: everything restarts from a clean note 0.
            state_n    = ST_NOTE;
            idx_n      = 2'd0;
            last_idx_n = st_last;
            base_n     = st_base;
            alt_n      = st_alt;
            hp_n       = '0;
            dur_n      = '0;
            spk_raw_n  = 1'b0;
        end else begin
            case (state)
                ST_NOTE: begin
                    if (hp_cnt == cur_half - CW'(1)) begin
                        hp_n      = '0;
                        spk_raw_n = ~spk_raw;
                    end else begin
                        hp_n = hp_cnt + CW'(1);
                    end
                    if (dur_cnt == DUR_M1) begin
                        hp_n      = '0;
                        dur_n     = '0;
                        spk_raw_n = 1'b0;
                        state_n   = (idx == last_idx) ? ST_IDLE : ST_GAP;
                    end else begin
                        dur_n = dur_cnt + CW'(1);
                    end
                end
                ST_GAP: begin
                    spk_raw_n = 1'b0;
                    hp_n      = '0;
                    if (dur_cnt == GAP_M1) begin
                        dur_n   = '0;
                        idx_n   = idx + 2'd1;
                        state_n = ST_NOTE;
                    end else begin
                        dur_n = dur_cnt + CW'(1);
                    end
                end
                default: begin
                    spk_raw_n = 1'b0;
                    hp_n      = '0;
                    dur_n     = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            idx      <= 2'd0;
            last_idx <= 2'd0;
            base_q   <= '0;
            alt_q    <= '0;
            hp_cnt   <= '0;
            dur_cnt  <= '0;
            spk_raw  <= 1'b0;
            spk_q    <= 1'b0;
            score_q  <= MID;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            last_idx <= last_idx_n;
            base_q   <= base_n;
            alt_q    <= alt_n;
            hp_cnt   <= hp_n;
            dur_cnt  <= dur_n;
            spk_raw  <= spk_raw_n;
            // Mute gating is folded into the output register so sound_en never reaches spk combinationally.
            spk_q    <= spk_raw_n & ev.sound_en;
            score_q  <= ev.score;
        end
    end

    assign ev.spk  = spk_q;
    assign ev.busy = (state != ST_IDLE);
endmodule

// File: tb/tb_game_sound_gen.sv
// tb/tb_game_sound_gen.sv - table-driven scoreboard bench for game_sound_gen
module tb_game_sound_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    game_sound_gen_if gif ();
    game_sound_gen dut (.clk(clk), .rst(rst), .ev(gif.slave));

    // kind: 0 none, 1 winrnd, 2 tie, 3 tie+winrnd together (all at cycle 0)
    typedef struct {
        int kind;
        bit right;
        bit en;
        int extra_win;
        int vic;
        bit vic_right;
        int ncyc;
    } vec_t;

    typedef struct {
        bit busy;
        bit spk;
    } exp_t;

    vec_t vecs[9];
    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    function automatic bit note_spk(input int c, input int s, input int h);
        int k;
        k = c - s;
        if (k < 0 || k >= 16) return 1'b0;
        return ((k / h) % 2) == 1;
    endfunction

    function automatic exp_t expect_at(input vec_t v, input int c);
        exp_t e;
        int   vs;
        int   h;
        e.busy = 1'b0;
        e.spk  = 1'b0;
        vs = (v.vic >= 0) ? v.vic + 1 : 32'h3fff_ffff;
        if (c < vs) begin
            if (v.kind == 1) begin
                h = v.right ? 2 : 3;
                e.busy = (c >= 1 && c <= 16);
                e.spk  = note_spk(c, 1, h);
            end else if (v.kind >= 2) begin
                e.busy = (c >= 1 && c <= 36);
                e.spk  = note_spk(c, 1, 4) | note_spk(c, 21, 4);
            end
        end else begin
            h = v.vic_right ? 2 : 3;
            e.busy = (c <= vs + 55);
            e.spk  = note_spk(c, vs, h) | note_spk(c, vs + 20, 4) | note_spk(c, vs + 40, h);
        end
        if (!v.en) e.spk = 1'b0;
        return e;
    endfunction

    task automatic check(input string name, input int c, input bit got, input bit want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0b want=%0b", name, c, got, want);
        end
    endtask

    task automatic drive_idle();
        gif.winrnd   = 1'b0;
        gif.right    = 1'b0;
        gif.tie      = 1'b0;
        gif.score    = 7'b0001000;
        gif.sound_en = 1'b1;
    endtask

    task automatic drive(input vec_t v, input int c);
        gif.winrnd   = (((v.kind == 1) || (v.kind == 3)) && c == 0) || (c == v.extra_win);
        gif.tie      = (v.kind >= 2) && c == 0;
        gif.right    = v.right;
        gif.sound_en = v.en;
        if (v.vic >= 0) begin
            if (c >= v.vic) gif.score = v.vic_right ? 7'b0000001 : 7'b1000000;
            else            gif.score = v.vic_right ? 7'b0000010 : 7'b0100000;
        end else begin
            gif.score = 7'b0001000;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive_idle();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        q.delete();
    endtask

    task automatic run_cycles(input vec_t v, input int n, input string tag);
        exp_t e;
        q.push_back(expect_at(v, 0));
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            e = q.pop_front();
            check({tag, ".busy"}, c, gif.busy, e.busy);
            check({tag, ".spk"}, c, gif.spk, e.spk);
            drive(v, c);
            q.push_back(expect_at(v, c + 1));
        end
    endtask

    initial begin
        exp_t  e;
        vec_t  hv;
        string tag;
        drive_idle();
        vecs[0] = '{0, 1'b0, 1'b1, -1, -1, 1'b0, 20};
        vecs[1] = '{1, 1'b1, 1'b1, -1, -1, 1'b0, 24};
        vecs[2] = '{1, 1'b0, 1'b1, -1, -1, 1'b0, 24};
        vecs[3] = '{3, 1'b1, 1'b1, -1, -1, 1'b0, 44};
        vecs[4] = '{2, 1'b0, 1'b1,  5, -1, 1'b0, 44};
        vecs[5] = '{1, 1'b0, 1'b1, -1,  6, 1'b0, 80};
        vecs[6] = '{1, 1'b1, 1'b1, -1,  6, 1'b1, 80};
        vecs[7] = '{1, 1'b1, 1'b0, -1, -1, 1'b0, 24};
        vecs[8] = '{2, 1'b0, 1'b1, -1, 18, 1'b1, 90};

        repeat (2) @(negedge clk);
        check("reset.busy", -1, gif.busy, 1'b0);
        check("reset.spk", -1, gif.spk, 1'b0);

        for (int i = 0; i < 9; i++) begin
            do_reset();
            tag = $sformatf("vec%0d", i);
            run_cycles(vecs[i], vecs[i].ncyc, tag);
        end

        // Asynchronous reset in the middle of a right-win note; the tone must not resume.
        do_reset();
        hv = '{1, 1'b1, 1'b1, -1, -1, 1'b0, 9};
        run_cycles(hv, 9, "rstmid");
        q.delete();
        @(negedge clk);
        drive_idle();
        check("rstmid.pre_busy", 9, gif.busy, 1'b1);
        check("rstmid.pre_spk", 9, gif.spk, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("rstmid.async_busy", 9, gif.busy, 1'b0);
        check("rstmid.async_spk", 9, gif.spk, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        e.busy = 1'b0;
        e.spk  = 1'b0;
        for (int c = 0; c < 12; c++) begin
            q.push_back(e);
            @(negedge clk);
            e = q.pop_front();
            check("rstmid.after_busy", c, gif.busy, e.busy);
            check("rstmid.after_spk", c, gif.spk, e.spk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/game_sound_gen.md
Name: game_sound_gen

Overview:
- Audio feedback generator for the tug-of-war game. It is the consumer end of the game-event interface: the round/tie/score signals that the game core drives out.
- It receives the round-win, direction, tie and score-position signals.
- It turns them into square-wave tone sequences on a single piezo speaker pin.
- It runs on the divided game clock `clk`, alongside the scorer and LED mux.

Parameters:
- HALF_R, 2, half-period in clk cycles of the right-player tone.
- HALF_L, 3, half-period in clk cycles of the left-player tone.
- HALF_T, 4, half-period in clk cycles of the tie tone.
- DUR, 16, length in clk cycles of one note.
- GAP, 4, silent clk cycles between notes of a multi-note sequence.
- CW, 8, width of the half-period and duration counters. Every parameter must be at most 2^CW-1.

Ports:
- clk  input  1  divided game clock
- rst  input  1  asynchronous, active-high reset
- winrnd  input  1  one-cycle pulse: a round was won
- right  input  1  qualifies winrnd: 1 = right player won, 0 = left player won
- tie  input  1  one-cycle pulse: tied round
- score  input  7  one-hot rope position. 7'b0000001 and 7'b1000000 are the match-end positions.
- sound_en  input  1  0 = mute (spk forced 0; the FSM still runs)
- spk  output  1  square-wave speaker drive
- busy  output  1  high while a sequence is playing

Behaviour:
- Reset (asynchronous, active-high) sets:
  - state = IDLE, spk = 0, busy = 0
  - all counters = 0
  - score_q (registered previous score) = 7'b0001000
- Match-end event (victory):
  - Fires when score != score_q and score is 7'b0000001 or 7'b1000000.
  - score_q updates every cycle.
- Event priority, sampled in the same cycle: victory > tie > winrnd.
- States: IDLE, NOTE, GAP.
  - An internal note index (0..2), a last-note flag and a selected half-period register describe the sequence.
- Sequences:
  - winrnd with right=1: one note at HALF_R.
  - winrnd with right=0: one note at HALF_L.
  - tie: HALF_T, GAP, HALF_T.
  - victory at 7'b1000000: HALF_L, GAP, HALF_T, GAP, HALF_L.
  - victory at 7'b0000001: the same three-note pattern with HALF_R in place of HALF_L.
- IDLE:
  - An accepted event at cycle n moves the FSM to NOTE at n+1, with note index = 0 and hp_cnt = dur_cnt = 0.
  - busy = 1 from n+1.
- NOTE:
  - hp_cnt counts 0..HALF-1. When it wraps, spk_raw toggles. spk_raw is 0 on note entry, so the first rising edge comes HALF cycles after entry.
  - dur_cnt counts 0..DUR-1. At DUR-1:
    - if this is the last note, go to IDLE;
    - otherwise go to GAP.
- GAP:
  - spk_raw = 0. Runs for GAP cycles, then enters NOTE for the next index with counters cleared.
- IDLE: spk_raw = 0 and busy = 0.
- spk = spk_raw AND sound_en, registered (no combinational path from sound_en).
- Events arriving while busy:
  - winrnd and tie are ignored (dropped, not queued).
  - victory preempts: it aborts the current sequence and starts the victory sequence next cycle, with counters and spk_raw cleared.
- winrnd and tie in the same cycle: tie wins.
- A victory that is not a change of score (score already at an end position) does not retrigger.
- Reset mid-sequence: immediate return to the reset values. The event is not resumed.
- The counters never exceed their terminal values. There is no wrap beyond HALF-1 or DUR-1.

Test Plan:
1. Assert rst, then release -> spk = 0, busy = 0. Score held at 7'b0001000 for 20 cycles -> no activity.
2. winrnd=1, right=1 pulse at cycle 0 (sound_en=1):
   - busy = 1 for cycles 1..16, 0 at cycle 17.
   - spk toggles every 2 cycles, first rise at cycle 3, 8 toggles total, 0 at cycle 17.
3. tie pulse together with winrnd at cycle 0:
   - Tie sequence plays: 16 cycles at half-period 4, then 4 silent cycles, then 16 cycles at half-period 4.
   - busy = 1 for cycles 1..36.
4. winrnd pulse at cycle 5 during a running tie sequence -> ignored; the tie sequence completes unchanged.
5. Score 7'b0100000 -> 7'b1000000 at cycle 6 of a left-win note:
   - At cycle 7 the victory sequence starts with spk = 0.
   - Notes at half-periods 3, 4, 3 with 4-cycle gaps; busy clears after 56 cycles.
   - Holding score at 7'b1000000 afterwards gives no retrigger.
6. sound_en = 0 during scenario 2 -> spk stays 0 and busy timing is identical. Pulsing rst at cycle 8 -> busy and spk are 0 immediately (asynchronous).
